multiplier: RTL

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier_pkg.sv | 13 +
 rtl/multiplier_if.sv | 24 ++
 rtl/multiplier_shift_add_step.sv | 20 ++
 rtl/multiplier.sv | 87 ++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
package multiplier_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CountW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/multiplier_if.sv
// Request/result bus for the multiplier; signal names line up with the divider bus.
interface multiplier_if #(
    parameter int unsigned WIDTH = multiplier_pkg::WIDTH
);

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;
    logic                 done;

    modport master (
        output start, a, b, c,
        input  p, busy, done
    );

    modport slave (
        input  start, a, b, c,
        output p, busy, done
    );

endinterface

// File: rtl/multiplier_shift_add_step.sv
// One shift-and-add iteration: conditionally adds the shifted multiplicand to acc.
module shift_add_step #(
    parameter int unsigned WIDTH  = multiplier_pkg::WIDTH,
    parameter int unsigned CountW = multiplier_pkg::CountW
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_a,
    input  logic               i_bit,
    input  logic [CountW-1:0]  i_count,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] w_addend;

    always_comb begin
        w_addend = {{WIDTH{1'b0}}, i_a} << i_count;
        o_acc    = i_bit ? (i_acc + w_addend) : i_acc;
    end

endmodule

// File: rtl/multiplier.sv
// Sequential unsigned multiply-accumulate p = a*b + c, one multiplier bit per cycle.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = multiplier_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    multiplier_if.slave  bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e               r_state;
    state_e               w_state_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CntW-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_p;
    logic                 r_done;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_last;

    assign w_last = (r_count == CntW'(WIDTH - 1));

    shift_add_step #(
        .WIDTH  (WIDTH),
        .CountW (CntW)
    ) u_step (
        .i_acc   (r_acc),
        .i_a     (r_a),
        .i_bit   (r_b[r_count]),
        .i_count (r_count),
        .o_acc   (w_acc_next)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_p     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_acc   <= {{WIDTH{1'b0}}, bus.c};
                        r_count <= '0;
                    end
                end
                StRun: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + CntW'(1);
                end
                StDone: begin
                    r_p    <= r_acc;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // done is registered, so it is visible in the IDLE cycle after DONE
    assign bus.p    = r_p;
    assign bus.done = r_done;
    assign bus.busy = (r_state == StRun) || (r_state == StDone);

endmodule
